// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared definitions for the multi-port register file and the
//                forwarding logic: default sizes, register address type, the
//                hardwired-zero register index and the bypass select function.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

  localparam int RF_WIDTH   = 32;
  localparam int RF_DEPTH_B = 5;

  typedef logic [RF_DEPTH_B-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  typedef enum logic [1:0] {
    BP_NONE = 2'd0,
    BP_P0   = 2'd1,
    BP_P1   = 2'd2
  } bp_sel_t;

  // Chooses the forwarding source for one read port. The write-back port (1)
  // outranks the early-writeback port (0), matching the array write priority.
  // Address comparison is done by the caller so the function is width-agnostic.
  function automatic bp_sel_t bypass_sel(
    input logic ra_nz,
    input logic we0,
    input logic hit0,
    input logic we1,
    input logic hit1
  );
    bp_sel_t sel;
    sel = BP_NONE;
    if (ra_nz) begin
      if (we1 && hit1)      sel = BP_P1;
      else if (we0 && hit0) sel = BP_P0;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register busy bits with set-over-clear priority and a
//                running count of busy registers. Bit 0 is never busy.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard #(
  parameter int DEPTH_B = 5,
  parameter int DEPTH   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_set_en,
  input  logic [DEPTH_B-1:0] i_set_addr,
  input  logic               i_clr0_en,
  input  logic [DEPTH_B-1:0] i_clr0_addr,
  input  logic               i_clr1_en,
  input  logic [DEPTH_B-1:0] i_clr1_addr,
  output logic [DEPTH-1:0]   o_busy,
  output logic [DEPTH_B:0]   o_cnt
);

  localparam int CNT_W = DEPTH_B + 1;

  logic [DEPTH-1:0] r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_set_v;
  logic             w_clr0_v;
  logic             w_clr1_v;
  logic             w_inc;
  logic             w_dec0;
  logic             w_dec1;

  assign w_set_v  = i_set_en  && (i_set_addr  != '0);
  assign w_clr0_v = i_clr0_en && (i_clr0_addr != '0);
  assign w_clr1_v = i_clr1_en && (i_clr1_addr != '0);

  // Next busy vector: clears first, then set overrides (newer producer wins).
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr0_v) w_busy_nxt[i_clr0_addr] = 1'b0;
    if (w_clr1_v) w_busy_nxt[i_clr1_addr] = 1'b0;
    if (w_set_v)  w_busy_nxt[i_set_addr]  = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Count transitions directly; a doubled clear of one register falls once.
  always_comb begin
    w_inc  = w_set_v && !r_busy[i_set_addr];
    w_dec0 = w_clr0_v && r_busy[i_clr0_addr]
             && !(w_set_v && (i_set_addr == i_clr0_addr));
    w_dec1 = w_clr1_v && r_busy[i_clr1_addr]
             && !(w_set_v && (i_set_addr == i_clr1_addr))
             && !(w_clr0_v && (i_clr0_addr == i_clr1_addr));
  end

  // Busy vector and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec0) - CNT_W'(w_dec1);
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/rf_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp_sb
//  Description : Multi-port register file, NREAD combinational read ports,
//                two prioritised write ports, optional write-to-read bypass
//                and a busy scoreboard for RAW hazard detection.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH_B = RF_DEPTH_B,
  parameter int DEPTH   = 32,
  parameter int NREAD   = 2,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREAD*DEPTH_B-1:0] rf_ra,
  output logic [NREAD*WIDTH-1:0]   rf_rd,
  output logic [NREAD-1:0]         rf_busy,
  input  logic                     rf_we0,
  input  logic [DEPTH_B-1:0]       rf_wa0,
  input  logic [WIDTH-1:0]         rf_wd0,
  input  logic                     rf_we1,
  input  logic [DEPTH_B-1:0]       rf_wa1,
  input  logic [WIDTH-1:0]         rf_wd1,
  input  logic                     sb_set,
  input  logic [DEPTH_B-1:0]       sb_wa,
  output logic [DEPTH_B:0]         busy_cnt,
  input  logic [DEPTH_B-1:0]       debug_reg_ra,
  output logic [WIDTH-1:0]         debug_reg_rd
);

  localparam logic [DEPTH_B-1:0] c_zero_addr = DEPTH_B'(ZERO_REG);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;

  // Data array; port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (rf_we0 && (rf_wa0 != c_zero_addr)) r_mem[rf_wa0] <= rf_wd0;
      if (rf_we1 && (rf_wa1 != c_zero_addr)) r_mem[rf_wa1] <= rf_wd1;
    end
  end

  rf_scoreboard #(
    .DEPTH_B (DEPTH_B),
    .DEPTH   (DEPTH)
  ) u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .i_set_en    (sb_set),
    .i_set_addr  (sb_wa),
    .i_clr0_en   (rf_we0),
    .i_clr0_addr (rf_wa0),
    .i_clr1_en   (rf_we1),
    .i_clr1_addr (rf_wa1),
    .o_busy      (w_busy),
    .o_cnt       (busy_cnt)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [DEPTH_B-1:0] w_ra;
    logic               w_ra_nz;
    bp_sel_t            w_sel;

    assign w_ra    = rf_ra[k*DEPTH_B +: DEPTH_B];
    assign w_ra_nz = (w_ra != c_zero_addr);

    if (BYPASS != 0) begin : g_bp
      assign w_sel = bypass_sel(w_ra_nz, rf_we0, rf_wa0 == w_ra,
                                rf_we1, rf_wa1 == w_ra);
    end else begin : g_nobp
      assign w_sel = BP_NONE;
    end

    // Read mux: zero register, forwarded write data, or the stored value.
    always_comb begin
      rf_rd[k*WIDTH +: WIDTH] = '0;
      if (w_ra_nz) begin
        case (w_sel)
          BP_P1:   rf_rd[k*WIDTH +: WIDTH] = rf_wd1;
          BP_P0:   rf_rd[k*WIDTH +: WIDTH] = rf_wd0;
          default: rf_rd[k*WIDTH +: WIDTH] = r_mem[w_ra];
        endcase
      end
    end

    // A forwarded operand is available now, so it does not stall.
    assign rf_busy[k] = w_ra_nz && (w_sel == BP_NONE) && w_busy[w_ra];
  end

  assign debug_reg_rd = r_mem[debug_reg_ra];

endmodule
`default_nettype wire

// File: tb/tb_rf_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_mp_sb
//  Description : Directed bench for rf_mp_sb; one bypassing and one
//                non-bypassing instance share all stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_mp_sb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  rf_ra;
  logic        rf_we0, rf_we1, sb_set;
  logic [4:0]  rf_wa0, rf_wa1, sb_wa, debug_reg_ra;
  logic [31:0] rf_wd0, rf_wd1;

  logic [63:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic [5:0]  cnt_b, cnt_n;
  logic [31:0] dbg_b, dbg_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_mp_sb #(.BYPASS(1)) u_dut (
    .clk(clk), .rstn(rstn), .rf_ra(rf_ra), .rf_rd(rd_b), .rf_busy(busy_b),
    .rf_we0(rf_we0), .rf_wa0(rf_wa0), .rf_wd0(rf_wd0),
    .rf_we1(rf_we1), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
    .sb_set(sb_set), .sb_wa(sb_wa), .busy_cnt(cnt_b),
    .debug_reg_ra(debug_reg_ra), .debug_reg_rd(dbg_b)
  );

  rf_mp_sb #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rstn(rstn), .rf_ra(rf_ra), .rf_rd(rd_n), .rf_busy(busy_n),
    .rf_we0(rf_we0), .rf_wa0(rf_wa0), .rf_wd0(rf_wd0),
    .rf_we1(rf_we1), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
    .sb_set(sb_set), .sb_wa(sb_wa), .busy_cnt(cnt_n),
    .debug_reg_ra(debug_reg_ra), .debug_reg_rd(dbg_n)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_we0 = 1'b0; rf_we1 = 1'b0; sb_set = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; rf_ra = '0; idle();
    rf_wa0 = '0; rf_wa1 = '0; rf_wd0 = '0; rf_wd1 = '0;
    sb_wa = '0; debug_reg_ra = '0;
    tick(); tick();
    #2 rstn = 1'b1;
    tick();

    // 1: all addresses read zero after reset, nothing busy
    for (int a = 0; a < 32; a++) begin
      rf_ra = {5'(a), 5'(31 - a)};
      #1;
      check($sformatf("rst_rd_a%0d", a), rd_b, 64'd0);
      check($sformatf("rst_busy_a%0d", a), {62'd0, busy_b}, 64'd0);
    end
    check("rst_cnt", {58'd0, cnt_b}, 64'd0);

    // 2: write x5 via port 0, bypass vs raw in the write cycle
    rf_ra = {5'd0, 5'd5};
    rf_we0 = 1'b1; rf_wa0 = 5'd5; rf_wd0 = 32'hDEADBEEF;
    #1;
    check("wr5_bypass", {32'd0, rd_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
    check("wr5_nobypass", {32'd0, rd_n[31:0]}, 64'd0);
    tick(); idle();
    debug_reg_ra = 5'd5;
    #1;
    check("rd5_bypass", {32'd0, rd_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
    check("rd5_nobypass", {32'd0, rd_n[31:0]}, 64'h0000_0000_DEAD_BEEF);
    check("dbg5", {32'd0, dbg_b}, 64'h0000_0000_DEAD_BEEF);

    // 3: both ports write x7, port 1 wins; debug read stays raw
    rf_ra = {5'd0, 5'd7}; debug_reg_ra = 5'd7;
    rf_we0 = 1'b1; rf_wa0 = 5'd7; rf_wd0 = 32'h11;
    rf_we1 = 1'b1; rf_wa1 = 5'd7; rf_wd1 = 32'h22;
    #1;
    check("x7_fwd_prio", {32'd0, rd_b[31:0]}, 64'h22);
    check("x7_dbg_raw", {32'd0, dbg_b}, 64'h0);
    tick(); idle();
    #1;
    check("x7_after_b", {32'd0, rd_b[31:0]}, 64'h22);
    check("x7_after_n", {32'd0, rd_n[31:0]}, 64'h22);

    // 4: set x3 busy, then clear it with a port-1 write
    sb_set = 1'b1; sb_wa = 5'd3;
    tick(); idle();
    rf_ra = {5'd0, 5'd3};
    #1;
    check("x3_busy", {62'd0, busy_b}, 64'd1);
    check("x3_cnt", {58'd0, cnt_b}, 64'd1);
    rf_we1 = 1'b1; rf_wa1 = 5'd3; rf_wd1 = 32'h33;
    #1;
    check("x3_busy_fwd", {62'd0, busy_b}, 64'd0);
    check("x3_busy_nofwd", {62'd0, busy_n}, 64'd1);
    check("x3_rd_fwd", {32'd0, rd_b[31:0]}, 64'h33);
    tick(); idle();
    #1;
    check("x3_cnt_clr", {58'd0, cnt_b}, 64'd0);
    check("x3_busy_clr_n", {62'd0, busy_n}, 64'd0);

    // 5: set and clear x9 in one cycle; set wins
    sb_set = 1'b1; sb_wa = 5'd9;
    rf_we0 = 1'b1; rf_wa0 = 5'd9; rf_wd0 = 32'h99;
    tick(); idle();
    rf_ra = {5'd0, 5'd9};
    #1;
    check("x9_busy", {62'd0, busy_b}, 64'd1);
    check("x9_cnt", {58'd0, cnt_b}, 64'd1);
    check("x9_data", {32'd0, rd_b[31:0]}, 64'h99);

    // 5b: writes and set on x0 have no effect
    rf_ra = {5'd0, 5'd0};
    rf_we0 = 1'b1; rf_wa0 = 5'd0; rf_wd0 = 32'hFFFF_FFFF;
    rf_we1 = 1'b1; rf_wa1 = 5'd0; rf_wd1 = 32'hFFFF_FFFF;
    sb_set = 1'b1; sb_wa = 5'd0;
    #1;
    check("x0_rd_wcycle", rd_b, 64'd0);
    tick(); idle();
    #1;
    check("x0_rd", rd_b, 64'd0);
    check("x0_busy", {62'd0, busy_b}, 64'd0);
    check("x0_cnt", {58'd0, cnt_b}, 64'd1);

    // 5c: re-set of a busy register keeps count
    sb_set = 1'b1; sb_wa = 5'd9;
    tick(); idle();
    check("x9_reset_cnt", {58'd0, cnt_b}, 64'd1);

    // 5d: two clears of different registers in one cycle (-2)
    sb_set = 1'b1; sb_wa = 5'd10;
    tick();
    sb_wa = 5'd11;
    tick(); idle();
    check("cnt_3", {58'd0, cnt_b}, 64'd3);
    rf_we0 = 1'b1; rf_wa0 = 5'd10; rf_wd0 = 32'hA;
    rf_we1 = 1'b1; rf_wa1 = 5'd11; rf_wd1 = 32'hB;
    tick(); idle();
    check("cnt_dual_clr", {58'd0, cnt_b}, 64'd1);

    // 5e: both ports clear x9 together: count falls by one only
    rf_we0 = 1'b1; rf_wa0 = 5'd9; rf_wd0 = 32'h1;
    rf_we1 = 1'b1; rf_wa1 = 5'd9; rf_wd1 = 32'h2;
    tick(); idle();
    check("cnt_same_clr", {58'd0, cnt_b}, 64'd0);
    check("cnt_same_clr_n", {58'd0, cnt_n}, 64'd0);

    // 6: four busy registers, then asynchronous reset between edges
    for (int r = 1; r <= 4; r++) begin
      sb_set = 1'b1; sb_wa = 5'(r);
      tick();
    end
    idle();
    check("cnt_4", {58'd0, cnt_b}, 64'd4);
    rf_ra = {5'd7, 5'd5}; debug_reg_ra = 5'd7;
    #2 rstn = 1'b0;
    #1;
    check("arst_cnt", {58'd0, cnt_b}, 64'd0);
    check("arst_rd", rd_b, 64'd0);
    check("arst_dbg", {32'd0, dbg_b}, 64'd0);
    rf_ra = {5'd0, 5'd2};
    #1;
    check("arst_busy", {62'd0, busy_b}, 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_cnt", {58'd0, cnt_b}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
